// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: IMEM request/response, decode-side valid/ready and branch redirect.
// master = fetch unit, slave = the environment (IMEM, decode, branch resolution).
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [15:0] if_pc;
    logic [15:0] if_instr;
    logic        redirect_valid;
    logic [15:0] redirect_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_valid, imem_rdata,
        output if_valid, if_pc, if_instr,
        input  if_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_valid, imem_rdata,
        input  if_valid, if_pc, if_instr,
        output if_ready,
        output redirect_valid, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one-outstanding IMEM requests, {pc, instr} FIFO toward decode, redirect flush, halt.
// Optional IFU_STATS_EN adds fetch_count / stall_count ports.
module instr_fetch_unit #(
    parameter int          DEPTH     = 4,
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
    input  logic               clock,
    input  logic               reset_n,
    instr_fetch_unit_if.master bus,
    output logic               halted
`ifdef IFU_STATS_EN
    ,
    output logic [15:0]        fetch_count,
    output logic [15:0]        stall_count
`endif
);
    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DRAIN, S_HALT} state_t;

    state_t        state_reg;
    logic [15:0]   fetch_pc_reg;
    logic          imem_req_reg;
    logic [15:0]   imem_addr_reg;
    logic          halted_reg;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW:0]   count_reg, count_next;
    logic          head_valid_reg;
    logic [15:0]   head_pc_reg;
    logic [15:0]   head_instr_reg;

    logic          push;
    logic          pop;
    logic          in_flight;

    assign pop  = head_valid_reg && !bus.redirect_valid && bus.if_ready;
    assign push = (state_reg == S_WAIT) && bus.imem_valid && !bus.redirect_valid;
    // A redirect only has to drain if the outstanding response has not arrived this very cycle.
    assign in_flight = ((state_reg == S_WAIT) || (state_reg == S_DRAIN)) && !bus.imem_valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= S_FETCH;
            fetch_pc_reg  <= RESET_PC;
            imem_req_reg  <= 1'b0;
            imem_addr_reg <= 16'h0000;
            halted_reg    <= 1'b0;
        end else begin
            imem_req_reg <= 1'b0;
            if (bus.redirect_valid) begin
                fetch_pc_reg <= bus.redirect_pc & 16'hFFFE;
                halted_reg   <= 1'b0;
                state_reg    <= in_flight ? S_DRAIN : S_FETCH;
            end else begin
                case (state_reg)
                    S_FETCH: begin
                        if (count_reg < FULL) begin
                            imem_req_reg  <= 1'b1;
                            imem_addr_reg <= fetch_pc_reg;
                            state_reg     <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (bus.imem_valid) begin
                            fetch_pc_reg <= fetch_pc_reg + 16'd2;
                            if (bus.imem_rdata == HALT_WORD) begin
                                state_reg  <= S_HALT;
                                halted_reg <= 1'b1;
                            end else begin
                                state_reg <= S_FETCH;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (bus.imem_valid) state_reg <= S_FETCH;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (bus.redirect_valid) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
            if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
            case ({push, pop})
                2'b10:   count_next = count_reg + (AW+1)'(1);
                2'b01:   count_next = count_reg - (AW+1)'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_reg] <= {fetch_pc_reg, bus.imem_rdata};
    end

    // Head is a registered read of the next head slot, bypassing the incoming word when it lands there.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            count_reg      <= '0;
            head_valid_reg <= 1'b0;
            head_pc_reg    <= 16'h0000;
            head_instr_reg <= 16'h0000;
        end else begin
            rd_ptr_reg     <= rd_ptr_next;
            wr_ptr_reg     <= wr_ptr_next;
            count_reg      <= count_next;
            head_valid_reg <= (count_next != '0);
            if (push && (wr_ptr_reg == rd_ptr_next)) begin
                head_pc_reg    <= fetch_pc_reg;
                head_instr_reg <= bus.imem_rdata;
            end else begin
                head_pc_reg    <= mem[rd_ptr_next][31:16];
                head_instr_reg <= mem[rd_ptr_next][15:0];
            end
        end
    end

    assign bus.imem_req  = imem_req_reg;
    assign bus.imem_addr = imem_addr_reg;
    assign bus.if_valid  = head_valid_reg && !bus.redirect_valid;
    assign bus.if_pc     = head_pc_reg;
    assign bus.if_instr  = head_instr_reg;
    assign halted        = halted_reg;

`ifdef IFU_STATS_EN
    logic [15:0] fetch_count_reg;
    logic [15:0] stall_count_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_count_reg <= 16'h0000;
            stall_count_reg <= 16'h0000;
        end else begin
            if (push) fetch_count_reg <= fetch_count_reg + 16'd1;
            if ((state_reg == S_FETCH) && (count_reg == FULL) && (stall_count_reg != 16'hFFFF))
                stall_count_reg <= stall_count_reg + 16'd1;
        end
    end

    assign fetch_count = fetch_count_reg;
    assign stall_count = stall_count_reg;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: IMEM responder with programmable latency, request/delivery logs.
// Build with IFU_STATS_EN defined to also cover the statistics counters.
module tb_instr_fetch_unit;
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic halted;
`ifdef IFU_STATS_EN
    logic [15:0] fetch_count;
    logic [15:0] stall_count;
`endif

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(
        .DEPTH     (4),
        .RESET_PC  (16'h0000),
        .HALT_WORD (16'hFFFF)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus),
        .halted  (halted)
`ifdef IFU_STATS_EN
        ,
        .fetch_count (fetch_count),
        .stall_count (stall_count)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s: %h", tag, got);
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // IMEM model
    int          lat      = 1;
    bit          halt_en  = 1'b0;
    logic [15:0] halt_addr = 16'h0000;
    bit          pend     = 1'b0;
    int          cnt      = 0;
    logic [15:0] pend_addr;

    function automatic logic [15:0] word_at(input logic [15:0] a);
        if (halt_en && (a == halt_addr)) return 16'hFFFF;
        return a ^ 16'h5A5A;
    endfunction

    always @(posedge clock) begin
        #1;
        bus.imem_valid = 1'b0;
        if (!reset_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    bus.imem_valid = 1'b1;
                    bus.imem_rdata = word_at(pend_addr);
                    pend = 1'b0;
                end
            end
            if (bus.imem_req) begin
                pend      = 1'b1;
                cnt       = lat;
                pend_addr = bus.imem_addr;
            end
        end
    end

    // Transaction logs, sampled mid-cycle
    int          cyc = 0;
    logic [15:0] req_q[$];
    logic [15:0] del_pc[$];
    logic [15:0] del_instr[$];
    int          del_cyc[$];
    int          vld_cyc[$];

    always @(negedge clock) begin
        cyc++;
        if (reset_n) begin
            if (bus.imem_req) begin
                req_q.push_back(bus.imem_addr);
                $display("req     addr=%h", bus.imem_addr);
            end
            if (bus.imem_valid) vld_cyc.push_back(cyc);
            if (bus.if_valid && bus.if_ready) begin
                del_pc.push_back(bus.if_pc);
                del_instr.push_back(bus.if_instr);
                del_cyc.push_back(cyc);
                $display("deliver pc=%h instr=%h", bus.if_pc, bus.if_instr);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n            = 1'b0;
        bus.if_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 16'h0000;
        repeat (3) tick();
        req_q.delete();
        del_pc.delete();
        del_instr.delete();
        del_cyc.delete();
        vld_cyc.delete();
    endtask

    task automatic wait_req(input int n, input int budget, input string tag);
        int i = 0;
        while ((req_q.size() < n) && (i < budget)) begin
            tick();
            i++;
        end
        check(tag, 32'(req_q.size() >= n), 32'd1);
    endtask

    task automatic wait_del(input int n, input int budget, input string tag);
        int i = 0;
        while ((del_pc.size() < n) && (i < budget)) begin
            tick();
            i++;
        end
        check(tag, 32'(del_pc.size() >= n), 32'd1);
    endtask

    task automatic pulse_redirect(input logic [15:0] pc);
        bus.redirect_pc    = pc;
        bus.redirect_valid = 1'b1;
        #1;
        check("redir_ifv_forced0", 32'(bus.if_valid), 32'd0);
        tick();
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        int n_req;
        int n_del;
        int i;
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 16'h0000;

        // 1: reset values, then in-order delivery with 1-cycle IMEM latency
        do_reset();
        check("rst_imem_req", 32'(bus.imem_req), 32'd0);
        check("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
        check("rst_if_valid", 32'(bus.if_valid), 32'd0);
        check("rst_if_pc", 32'(bus.if_pc), 32'd0);
        check("rst_if_instr", 32'(bus.if_instr), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        lat = 1;
        bus.if_ready = 1'b1;
        reset_n = 1'b1;
        wait_del(3, 40, "t1_del_timeout");
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t1_pc%0d", k), 32'(del_pc[k]), 32'(2 * k));
            check($sformatf("t1_instr%0d", k), 32'(del_instr[k]), 32'(word_at(16'(2 * k))));
            check($sformatf("t1_lat%0d", k), 32'(del_cyc[k] - vld_cyc[k]), 32'd1);
        end

        // 2: decode stalled -> exactly DEPTH requests, then drain and resume at 8
        do_reset();
        lat = 1;
        reset_n = 1'b1;
        repeat (30) tick();
        check("t2_nreq", 32'(req_q.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            check($sformatf("t2_addr%0d", k), 32'(req_q[k]), 32'(2 * k));
        check("t2_head_valid", 32'(bus.if_valid), 32'd1);
        check("t2_head_pc", 32'(bus.if_pc), 32'd0);
`ifdef IFU_STATS_EN
        check("t2_fetch_count", 32'(fetch_count), 32'd4);
        check("t2_stall_nonzero", 32'(stall_count != 16'h0000), 32'd1);
`endif
        bus.if_ready = 1'b1;
        wait_del(5, 40, "t2_del_timeout");
        for (int k = 0; k < 5; k++)
            check($sformatf("t2_del_pc%0d", k), 32'(del_pc[k]), 32'(2 * k));
        check("t2_resume_addr", 32'(req_q[4]), 32'h0008);

        // 3: redirect while a response is in flight
        do_reset();
        lat = 3;
        bus.if_ready = 1'b1;
        reset_n = 1'b1;
        wait_req(2, 40, "t3_req_timeout");
        n_req = req_q.size();
        n_del = del_pc.size();
        pulse_redirect(16'h0021);
        check("t3_fifo_empty", 32'(bus.if_valid), 32'd0);
        wait_req(n_req + 1, 40, "t3_req2_timeout");
        check("t3_next_addr", 32'(req_q[n_req]), 32'h0020);
        wait_del(n_del + 1, 40, "t3_del_timeout");
        check("t3_first_pc", 32'(del_pc[n_del]), 32'h0020);
        check("t3_first_instr", 32'(del_instr[n_del]), 32'(word_at(16'h0020)));

        // 4: halt word at address 10, then restart by redirect
        do_reset();
        lat = 1;
        halt_en = 1'b1;
        halt_addr = 16'h000A;
        bus.if_ready = 1'b1;
        reset_n = 1'b1;
        repeat (40) tick();
        check("t4_nreq", 32'(req_q.size()), 32'd6);
        check("t4_ndel", 32'(del_pc.size()), 32'd6);
        check("t4_halt_pc", 32'(del_pc[5]), 32'h000A);
        check("t4_halt_instr", 32'(del_instr[5]), 32'hFFFF);
        check("t4_halted", 32'(halted), 32'd1);
        pulse_redirect(16'h0000);
        check("t4_unhalted", 32'(halted), 32'd0);
        wait_req(7, 5, "t4_req_timeout");
        check("t4_restart_addr", 32'(req_q[6]), 32'h0000);
        halt_en = 1'b0;

        // 5: PC wraps from FFFE to 0000
        do_reset();
        lat = 1;
        bus.if_ready = 1'b1;
        reset_n = 1'b1;
        repeat (5) tick();
        n_del = del_pc.size();
        pulse_redirect(16'hFFFE);
        wait_del(n_del + 2, 40, "t5_del_timeout");
        check("t5_pc0", 32'(del_pc[n_del]), 32'hFFFE);
        check("t5_instr0", 32'(del_instr[n_del]), 32'(word_at(16'hFFFE)));
        check("t5_pc1", 32'(del_pc[n_del + 1]), 32'h0000);
        check("t5_instr1", 32'(del_instr[n_del + 1]), 32'(word_at(16'h0000)));

        // 6: reset asserted while the 4th request is outstanding and 3 entries are held
        do_reset();
        lat = 3;
        reset_n = 1'b1;
        i = 0;
        while (!(bus.imem_req && (req_q.size() == 3)) && (i < 60)) begin
            tick();
            i++;
        end
        check("t6_reach", 32'(i < 60), 32'd1);
        check("t6_pre_ifvalid", 32'(bus.if_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t6_imem_req", 32'(bus.imem_req), 32'd0);
        check("t6_imem_addr", 32'(bus.imem_addr), 32'd0);
        check("t6_if_valid", 32'(bus.if_valid), 32'd0);
        check("t6_if_pc", 32'(bus.if_pc), 32'd0);
        check("t6_if_instr", 32'(bus.if_instr), 32'd0);
        check("t6_halted", 32'(halted), 32'd0);
`ifdef IFU_STATS_EN
        check("t6_fetch_count", 32'(fetch_count), 32'd0);
        check("t6_stall_count", 32'(stall_count), 32'd0);
`endif
        do_reset();
        lat = 1;
        bus.if_ready = 1'b1;
        reset_n = 1'b1;
        wait_del(1, 20, "t6_del_timeout");
        check("t6_restart_pc", 32'(del_pc[0]), 32'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
